// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard receiver that tracks the held WASD direction key as a HID code.
// Define PS2_ARROW_KEYS_EN to also decode the extended (E0-prefixed) arrow keys.
module ps2_keycode_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       PS2_Clk,
  input  logic       PS2_Data,
  output logic [7:0] keycode,
  output logic       Key_Valid,
  output logic       Frame_Err
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t                state, state_n;
  logic                  clk_s1, clk_s2, dat_s1, dat_s2, clk_filt;
  logic [FILTER_LEN-1:0] clk_hist;
  logic [2:0]            bit_cnt, bit_cnt_n;
  logic [7:0]            shift, shift_n;
  logic                  par, par_n;
  logic [TW-1:0]         tmo_cnt;
  logic                  fall, tmo_hit, byte_ok, frame_err_n;
  logic                  brk, brk_n, ext, ext_n;
  logic [7:0]            key_n, hid;

  // Synchronizers and clock stability filter; everything idles high.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
      clk_hist <= '1;
      clk_filt <= 1'b1;
    end else begin
      clk_s1   <= PS2_Clk;
      clk_s2   <= clk_s1;
      dat_s1   <= PS2_Data;
      dat_s2   <= dat_s1;
      clk_hist <= {clk_hist[FILTER_LEN-2:0], clk_s2};
      if (&clk_hist)
        clk_filt <= 1'b1;
      else if (~|clk_hist)
        clk_filt <= 1'b0;
    end
  end

  assign fall    = clk_filt && ~|clk_hist;
  assign tmo_hit = (state != IDLE) && !fall && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    shift_n     = shift;
    par_n       = par;
    byte_ok     = 1'b0;
    frame_err_n = 1'b0;
    if (tmo_hit) begin
      state_n     = IDLE;
      frame_err_n = 1'b1;
    end else if (fall) begin
      case (state)
        IDLE: begin
          if (!dat_s2) begin
            state_n   = DATA;
            bit_cnt_n = 3'd0;
          end
        end
        DATA: begin
          shift_n   = {dat_s2, shift[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7)
            state_n = PARITY;
        end
        PARITY: begin
          par_n   = dat_s2;
          state_n = STOP;
        end
        STOP: begin
          state_n = IDLE;
          if (dat_s2 && ^{shift, par})
            byte_ok = 1'b1;
          else
            frame_err_n = 1'b1;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Prefix flags and key translation for each accepted byte.
  always_comb begin
    brk_n = brk;
    ext_n = ext;
    key_n = keycode;
    hid   = 8'h00;
    if (byte_ok) begin
      if (shift == 8'hF0) begin
        brk_n = 1'b1;
      end else if (shift == 8'hE0) begin
        ext_n = 1'b1;
      end else begin
        if (!ext) begin
          case (shift)
            8'h1C:   hid = 8'h04;
            8'h23:   hid = 8'h07;
            8'h1B:   hid = 8'h16;
            8'h1D:   hid = 8'h1A;
            default: hid = 8'h00;
          endcase
        end
`ifdef PS2_ARROW_KEYS_EN
        else begin
          case (shift)
            8'h6B:   hid = 8'h04;
            8'h74:   hid = 8'h07;
            8'h72:   hid = 8'h16;
            8'h75:   hid = 8'h1A;
            default: hid = 8'h00;
          endcase
        end
`endif
        if (hid != 8'h00) begin
          if (!brk)
            key_n = hid;
          else if (keycode == hid)
            key_n = 8'h00;
        end
        brk_n = 1'b0;
        ext_n = 1'b0;
      end
    end
    if (tmo_hit) begin
      brk_n = 1'b0;
      ext_n = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state     <= IDLE;
      bit_cnt   <= 3'd0;
      shift     <= 8'h00;
      par       <= 1'b0;
      tmo_cnt   <= '0;
      brk       <= 1'b0;
      ext       <= 1'b0;
      keycode   <= 8'h00;
      Key_Valid <= 1'b0;
      Frame_Err <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      shift     <= shift_n;
      par       <= par_n;
      brk       <= brk_n;
      ext       <= ext_n;
      keycode   <= key_n;
      Key_Valid <= (key_n != keycode);
      Frame_Err <= frame_err_n;
      if (state == IDLE || fall)
        tmo_cnt <= '0;
      else
        tmo_cnt <= tmo_cnt + TW'(1);
    end
  end
endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Self-checking bench for ps2_keycode_rx: directed frames plus random frames against a byte-level key model.
module tb_ps2_keycode_rx;
  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 5000;
  localparam int H          = 20;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       PS2_Clk = 1'b1;
  logic       PS2_Data = 1'b1;
  logic [7:0] keycode;
  logic       Key_Valid;
  logic       Frame_Err;

  int chk_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  int kv_cnt = 0;
  int fe_cnt = 0;
  int kv_cyc = 0;
  int stop_cyc = 0;

  logic [7:0] m_key = 8'h00;
  bit         m_brk = 1'b0;
  bit         m_ext = 1'b0;

  ps2_keycode_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .Clk(Clk), .Reset(Reset), .PS2_Clk(PS2_Clk), .PS2_Data(PS2_Data),
    .keycode(keycode), .Key_Valid(Key_Valid), .Frame_Err(Frame_Err)
  );

  initial forever #10 Clk = ~Clk;
  initial forever begin
    @(posedge Clk);
    cyc = cyc + 1;
  end

  task automatic chk(input string tag, input int got, input int exp);
    chk_cnt = chk_cnt + 1;
    if (got !== exp) begin
      err_cnt = err_cnt + 1;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Output monitor: pulse counting and Key_Valid coinciding with every keycode change.
  initial begin
    logic [7:0] prev_key;
    logic       prev_rst;
    prev_key = 8'h00;
    prev_rst = 1'b0;
    forever begin
      @(negedge Clk);
      if (Reset && prev_rst) begin
        if (Key_Valid) begin
          kv_cnt = kv_cnt + 1;
          kv_cyc = cyc;
        end
        if (Frame_Err) fe_cnt = fe_cnt + 1;
        if (Key_Valid || keycode != prev_key)
          chk("kv_align", int'(Key_Valid), int'(keycode != prev_key));
      end
      prev_key = keycode;
      prev_rst = Reset;
    end
  end

  function automatic logic [7:0] ref_map(input logic [7:0] code, input bit e);
    logic [7:0] plain[4] = '{8'h1C, 8'h23, 8'h1B, 8'h1D};
    logic [7:0] arrow[4] = '{8'h6B, 8'h74, 8'h72, 8'h75};
    logic [7:0] usage[4] = '{8'h04, 8'h07, 8'h16, 8'h1A};
    ref_map = 8'h00;
    for (int i = 0; i < 4; i++) begin
      if (!e && code == plain[i]) ref_map = usage[i];
`ifdef PS2_ARROW_KEYS_EN
      if (e && code == arrow[i]) ref_map = usage[i];
`else
      if (e && code == arrow[i]) ref_map = 8'h00;
`endif
    end
  endfunction

  task automatic ref_byte(input logic [7:0] b, output bit changed);
    logic [7:0] h, old;
    old = m_key;
    if (b == 8'hF0) m_brk = 1'b1;
    else if (b == 8'hE0) m_ext = 1'b1;
    else begin
      h = ref_map(b, m_ext);
      if (h != 8'h00) begin
        if (!m_brk) m_key = h;
        else if (m_key == h) m_key = 8'h00;
      end
      m_brk = 1'b0;
      m_ext = 1'b0;
    end
    changed = (m_key != old);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                           input int nbits, input bit glitch);
    logic [10:0] fr;
    fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      PS2_Data = fr[i];
      if (glitch) begin
        wait_cyc(3 * H / 4);
        PS2_Clk = 1'b0;
        wait_cyc(1);
        PS2_Clk = 1'b1;
        wait_cyc(H - 3 * H / 4 - 1);
      end else wait_cyc(H);
      PS2_Clk = 1'b0;
      if (i == 10) stop_cyc = cyc;
      if (glitch) begin
        wait_cyc(3 * H / 4);
        PS2_Clk = 1'b1;
        wait_cyc(1);
        PS2_Clk = 1'b0;
        wait_cyc(H - 3 * H / 4 - 1);
      end else wait_cyc(H);
      PS2_Clk = 1'b1;
    end
    PS2_Data = 1'b1;
  endtask

  task automatic do_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input bit glitch);
    int kv0, fe0, lat;
    bit ok, chg;
    ok  = !bad_par && !bad_stop;
    chg = 1'b0;
    if (ok) ref_byte(b, chg);
    kv0 = kv_cnt;
    fe0 = fe_cnt;
    send_bits(b, bad_par, bad_stop, 11, glitch);
    wait_cyc(30);
    chk("keycode", int'(keycode), int'(m_key));
    chk("key_valid_pulses", kv_cnt - kv0, int'(chg));
    chk("frame_err_pulses", fe_cnt - fe0, int'(!ok));
    if (chg) begin
      lat = kv_cyc - stop_cyc;
      chk("update_latency", int'(lat >= FILTER_LEN && lat <= FILTER_LEN + 4), 1);
    end
  endtask

  initial begin
    int fe0;
    logic [7:0] pool[10] = '{8'h1C, 8'h23, 8'h1B, 8'h1D, 8'hF0, 8'hE0, 8'h6B, 8'h74, 8'h72, 8'h75};
    logic [7:0] code;
    int idx, r;

    wait_cyc(5);
    chk("rst_keycode", int'(keycode), 0);
    chk("rst_key_valid", int'(Key_Valid), 0);
    chk("rst_frame_err", int'(Frame_Err), 0);
    Reset = 1'b1;
    wait_cyc(20);

    // Single make, then a typematic repeat.
    do_frame(8'h1C, 0, 0, 0);
    do_frame(8'h1C, 0, 0, 0);
    // Last pressed wins; break of a non-held key is ignored.
    do_frame(8'h23, 0, 0, 0);
    do_frame(8'hF0, 0, 0, 0);
    do_frame(8'h1C, 0, 0, 0);
    do_frame(8'hF0, 0, 0, 0);
    do_frame(8'h23, 0, 0, 0);
    // Extended arrow make/break.
    do_frame(8'hE0, 0, 0, 0);
    do_frame(8'h75, 0, 0, 0);
    do_frame(8'hE0, 0, 0, 0);
    do_frame(8'hF0, 0, 0, 0);
    do_frame(8'h75, 0, 0, 0);
    // Parity and stop errors leave state alone.
    do_frame(8'h1D, 1, 0, 0);
    do_frame(8'h1D, 0, 0, 0);
    do_frame(8'hF0, 0, 1, 0);
    do_frame(8'h1D, 0, 0, 0);
    // Glitchy clock.
    do_frame(8'h1C, 0, 0, 1);

    // Reset in the middle of a frame.
    fe0 = fe_cnt;
    send_bits(8'h23, 0, 0, 4, 0);
    Reset = 1'b0;
    wait_cyc(3);
    chk("midrst_keycode", int'(keycode), 0);
    chk("midrst_key_valid", int'(Key_Valid), 0);
    chk("midrst_frame_err", int'(Frame_Err), 0);
    m_key = 8'h00;
    m_brk = 1'b0;
    m_ext = 1'b0;
    Reset = 1'b1;
    wait_cyc(20);
    chk("midrst_no_err", fe_cnt - fe0, 0);
    do_frame(8'h23, 0, 0, 0);

    // Timeout on a partial frame discards a pending F0 prefix.
    do_frame(8'hF0, 0, 0, 0);
    fe0 = fe_cnt;
    send_bits(8'h1B, 0, 0, 5, 0);
    wait_cyc(TIMEOUT + 200);
    chk("timeout_err", fe_cnt - fe0, 1);
    chk("timeout_keycode", int'(keycode), int'(m_key));
    m_brk = 1'b0;
    m_ext = 1'b0;
    do_frame(8'h1B, 0, 0, 0);

    for (int n = 0; n < 50; n++) begin
      idx = $urandom_range(0, 11);
      if (idx >= 10) code = 8'($urandom_range(0, 255));
      else code = pool[idx];
      r = $urandom_range(0, 9);
      do_frame(code, r == 0, r == 1, 0);
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/ps2_keycode_rx.md
PS2_KEYCODE_RX -- requirements
Module: ps2_keycode_rx

Interface
REQ-001 Parameters SHALL be: FILTER_LEN, default 8, number of consecutive equal samples that make a PS2_Clk level stable; TIMEOUT_CYCLES, default 5000, idle Clk cycles after which a partial frame is aborted.
REQ-002 Clk  in  1  system clock, 50 MHz; one clock for the whole block, all state on rising edge.
REQ-003 Reset  in  1  synchronous, active-low reset.
REQ-004 PS2_Clk  in  1  asynchronous PS/2 device clock.
REQ-005 PS2_Data  in  1  asynchronous PS/2 device data.
REQ-006 keycode  out  8  HID code of the held direction key, 8'h00 when none held.
REQ-007 Key_Valid  out  1  one-cycle pulse when keycode changes value.
REQ-008 Frame_Err  out  1  one-cycle pulse on parity error, bad stop bit or timeout.

Function
REQ-009 PS2_Clk and PS2_Data SHALL each pass through a 2-flop synchronizer; PS2_Clk SHALL then pass through a FILTER_LEN-sample stability filter.
REQ-010 A PS2_Clk falling edge is a filtered 1->0 transition; data SHALL be sampled from synchronized PS2_Data in that cycle.
REQ-011 Frame FSM states SHALL be IDLE, DATA, PARITY, STOP.
- IDLE: on an edge with data 0 (start bit) -> DATA, bit count 0; an edge with data 1 -> stays IDLE, no error.
- DATA: shift bit in LSB first; after 8th bit -> PARITY.
- PARITY: store bit -> STOP.
- STOP: on edge, if stop=1 and the 9 data+parity bits have odd parity -> byte accepted, else Frame_Err; always -> IDLE.
REQ-012 The timeout counter SHALL clear on every falling edge and in IDLE; reaching TIMEOUT_CYCLES outside IDLE SHALL pulse Frame_Err and force IDLE, discarding the partial byte and any pending F0/E0 prefix.
REQ-013 The decoder SHALL keep flags brk and ext: byte F0 sets brk; byte E0 sets ext; any other accepted byte is decoded and then clears both.
REQ-014 Translation, ext=0: 1C->04 (A), 23->07 (D), 1B->16 (S), 1D->1A (W); all other codes ignored with no output change.
REQ-015 Make (brk=0) of a mapped key SHALL set keycode to its HID code (last pressed wins).
REQ-016 Break (brk=1) of a mapped key SHALL set keycode to 00 only if keycode equals that key's HID code, else no change.
REQ-017 Latency: keycode SHALL update exactly 1 Clk after the cycle in which the stop-bit edge is detected; Key_Valid SHALL pulse in that same cycle only if the new value differs from the old.
REQ-018 A byte failing parity or stop SHALL not touch keycode, brk or ext.
REQ-019 Typematic repeats of the current key SHALL produce no Key_Valid.

Reset
REQ-020 While Reset=0 at a Clk edge: FSM IDLE, bit count 0, shift register 0, brk=ext=0, timeout 0, keycode=00, Key_Valid=0, Frame_Err=0; synchronizer and filter flops SHALL be set to 1 (bus idle).
REQ-021 Reset asserted mid-frame SHALL abort the frame with no Frame_Err; the first frame after release SHALL decode normally.

Configuration
REQ-022 Macro PS2_ARROW_KEYS_EN defined: with ext=1, E0 6B->04, E0 74->07, E0 72->16, E0 75->1A, with the same make/break rules as REQ-015/016.
REQ-023 PS2_ARROW_KEYS_EN undefined: all ext=1 codes SHALL be ignored (flags still cleared) and no arrow logic SHALL be synthesized.

Verification
REQ-024 Frame 1C, valid parity, 10 kHz PS2_Clk -> keycode=04 one Clk after the stop edge, one Key_Valid pulse, Frame_Err=0.
REQ-025 Frames 1C then 23, then F0 1C -> keycode 04, 07, then stays 07; then F0 23 -> keycode=00, Key_Valid pulse.
REQ-026 Frame 1D with parity bit inverted -> Frame_Err pulse, keycode unchanged (00); next valid 1D -> 1A.
REQ-027 Start bit plus 4 data bits, then PS2_Clk held high 5000 cycles -> Frame_Err pulse, FSM IDLE; following full frame 1B -> keycode=16.
REQ-028 With PS2_ARROW_KEYS_EN: E0 75 -> 1A, E0 F0 75 -> 00; without it: the same bytes -> keycode stays 00, no Key_Valid.
REQ-029 1-cycle glitches on PS2_Clk during a 1C frame -> no extra bits, keycode=04; Reset=0 mid-frame -> all outputs 00/0 and next frame decodes.
